// File: rtl/pipeline_dec_exe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_dec_exe_reg : decode-to-execute register with stall/flush/valid |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module pipeline_dec_exe_reg #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic [WIDTH-1:0]  RD1D,
  input  logic [WIDTH-1:0]  RD2D,
  input  logic [WIDTH-1:0]  PCD,
  input  logic [WIDTH-1:0]  ExtImmD,
  input  logic [WIDTH-1:0]  PCPlus4D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              MemWriteD,
  input  logic              MemReadD,
  input  logic [2:0]        PcSrcD,
  input  logic [3:0]        ALUctrlD,
  input  logic              ALUsrcD,
  input  logic              WD3SrcD,
  input  logic [2:0]        AddrModeD,
  output logic              ValidE,
  output logic [WIDTH-1:0]  RD1E,
  output logic [WIDTH-1:0]  RD2E,
  output logic [WIDTH-1:0]  PCE,
  output logic [WIDTH-1:0]  ExtImmE,
  output logic [WIDTH-1:0]  PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              RegWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              MemWriteE,
  output logic              MemReadE,
  output logic [2:0]        PcSrcE,
  output logic [3:0]        ALUctrlE,
  output logic              ALUsrcE,
  output logic              WD3SrcE,
  output logic [2:0]        AddrModeE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  BubbleCnt
);

  localparam int BW = 5*WIDTH + 3*REG_AW + 17;

  logic [BW-1:0]    bundle_d, bundle_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic             stall_inc, bubble_inc;

  // Whole D-side bundle travels as one vector so no field can be missed.
  assign bundle_d = {RD1D, RD2D, PCD, ExtImmD, PCPlus4D, Rs1D, Rs2D, RdD,
                     RegWriteD, ResultSrcD, MemWriteD, MemReadD, PcSrcD,
                     ALUctrlD, ALUsrcD, WD3SrcD, AddrModeD};

  assign {RD1E, RD2E, PCE, ExtImmE, PCPlus4E, Rs1E, Rs2E, RdE,
          RegWriteE, ResultSrcE, MemWriteE, MemReadE, PcSrcE,
          ALUctrlE, ALUsrcE, WD3SrcE, AddrModeE} = bundle_q;

  assign ValidE    = valid_q;
  assign StallCnt  = stall_cnt_q;
  assign BubbleCnt = bubble_cnt_q;

  // A flush only counts as a bubble if it kills an instruction that would
  // otherwise have occupied the E slot.
  assign stall_inc  = StallE & ~FlushE;
  assign bubble_inc = FlushE & (StallE ? valid_q : ValidD);

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bubble_inc && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_comb begin
    valid_d = valid_q;
    if (FlushE)
      valid_d = 1'b0;
    else if (!StallE)
      valid_d = ValidD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bundle_q     <= '0;
      valid_q      <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (FlushE)
        bundle_q <= '0;
      else if (!StallE)
        bundle_q <= bundle_d;
      valid_q      <= valid_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_dec_exe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_dec_exe_reg : directed self-checking bench                   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pipeline_dec_exe_reg;

  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              StallE, FlushE, ValidD;
  logic [WIDTH-1:0]  RD1D, RD2D, PCD, ExtImmD, PCPlus4D;
  logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
  logic              RegWriteD, MemWriteD, MemReadD, ALUsrcD, WD3SrcD;
  logic [1:0]        ResultSrcD;
  logic [2:0]        PcSrcD, AddrModeD;
  logic [3:0]        ALUctrlD;
  logic              ValidE;
  logic [WIDTH-1:0]  RD1E, RD2E, PCE, ExtImmE, PCPlus4E;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic              RegWriteE, MemWriteE, MemReadE, ALUsrcE, WD3SrcE;
  logic [1:0]        ResultSrcE;
  logic [2:0]        PcSrcE, AddrModeE;
  logic [3:0]        ALUctrlE;
  logic [CNT_W-1:0]  StallCnt, BubbleCnt;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_dec_exe_reg #(.WIDTH(WIDTH), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ExtImmD(ExtImmD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .MemReadD(MemReadD),
    .PcSrcD(PcSrcD), .ALUctrlD(ALUctrlD), .ALUsrcD(ALUsrcD), .WD3SrcD(WD3SrcD),
    .AddrModeD(AddrModeD), .ValidE(ValidE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ExtImmE(ExtImmE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
    .PcSrcE(PcSrcE), .ALUctrlE(ALUctrlE), .ALUsrcE(ALUsrcE), .WD3SrcE(WD3SrcE),
    .AddrModeE(AddrModeE), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic [WIDTH-1:0] pc, input logic valid);
    PCD = pc;  PCPlus4D = pc + 32'd4;  ValidD = valid;
    RD1D = 32'hAAAA_0001;  RD2D = 32'h5555_0002;  ExtImmD = 32'hFFFF_F800;
    Rs1D = 5'd3;  Rs2D = 5'd17;  RdD = 5'd5;
    RegWriteD = 1'b1;  ResultSrcD = 2'd2;  MemWriteD = 1'b0;  MemReadD = 1'b1;
    PcSrcD = 3'd5;  ALUctrlD = 4'h9;  ALUsrcD = 1'b1;  WD3SrcD = 1'b1;
    AddrModeD = 3'd6;
  endtask

  initial begin
    rst = 1'b1;  StallE = 1'b0;  FlushE = 1'b0;
    drive_all(32'h55, 1'b1);
    tick();
    check_value("rst_pce",    64'(PCE), 64'h0);
    check_value("rst_valid",  64'(ValidE), 64'h0);
    check_value("rst_regwr",  64'(RegWriteE), 64'h0);
    check_value("rst_stallc", 64'(StallCnt), 64'h0);

    // Reset then load
    rst = 1'b0;
    drive_all(32'h100, 1'b1);
    tick();
    check_value("ld_pce",    64'(PCE), 64'h100);
    check_value("ld_rde",    64'(RdE), 64'd5);
    check_value("ld_regwr",  64'(RegWriteE), 64'd1);
    check_value("ld_valid",  64'(ValidE), 64'd1);
    check_value("ld_rd1",    64'(RD1E), 64'hAAAA_0001);
    check_value("ld_rd2",    64'(RD2E), 64'h5555_0002);
    check_value("ld_imm",    64'(ExtImmE), 64'hFFFF_F800);
    check_value("ld_pc4",    64'(PCPlus4E), 64'h104);
    check_value("ld_rs1",    64'(Rs1E), 64'd3);
    check_value("ld_rs2",    64'(Rs2E), 64'd17);
    check_value("ld_ressrc", 64'(ResultSrcE), 64'd2);
    check_value("ld_memrd",  64'(MemReadE), 64'd1);
    check_value("ld_memwr",  64'(MemWriteE), 64'd0);
    check_value("ld_pcsrc",  64'(PcSrcE), 64'd5);
    check_value("ld_alu",    64'(ALUctrlE), 64'h9);
    check_value("ld_alusrc", 64'(ALUsrcE), 64'd1);
    check_value("ld_wd3",    64'(WD3SrcE), 64'd1);
    check_value("ld_amode",  64'(AddrModeE), 64'd6);

    // Stall hold for three edges
    StallE = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      PCD = 32'h100 + 32'(4*i);
      tick();
      check_value("stall_pce", 64'(PCE), 64'h100);
      check_value("stall_cnt", 64'(StallCnt), 64'(i));
    end
    check_value("stall_valid", 64'(ValidE), 64'd1);
    StallE = 1'b0;
    tick();
    check_value("rel_pce", 64'(PCE), 64'h10C);
    check_value("rel_cnt", 64'(StallCnt), 64'd3);

    // Flush bubble of a valid store
    MemWriteD = 1'b1;  ALUctrlD = 4'h3;  PCD = 32'h110;
    tick();
    check_value("st_memwr", 64'(MemWriteE), 64'd1);
    check_value("st_alu",   64'(ALUctrlE), 64'h3);
    FlushE = 1'b1;
    tick();
    check_value("fl_pce",    64'(PCE), 64'h0);
    check_value("fl_rd1",    64'(RD1E), 64'h0);
    check_value("fl_memwr",  64'(MemWriteE), 64'd0);
    check_value("fl_alu",    64'(ALUctrlE), 64'h0);
    check_value("fl_regwr",  64'(RegWriteE), 64'd0);
    check_value("fl_memrd",  64'(MemReadE), 64'd0);
    check_value("fl_valid",  64'(ValidE), 64'd0);
    check_value("fl_bubble", 64'(BubbleCnt), 64'd1);

    // Flush beats stall
    FlushE = 1'b0;  PCD = 32'h114;
    tick();
    check_value("fs_pre_valid", 64'(ValidE), 64'd1);
    StallE = 1'b1;  FlushE = 1'b1;
    tick();
    check_value("fs_pce",    64'(PCE), 64'h0);
    check_value("fs_valid",  64'(ValidE), 64'd0);
    check_value("fs_stallc", 64'(StallCnt), 64'd3);
    check_value("fs_bubble", 64'(BubbleCnt), 64'd2);
    StallE = 1'b0;  ValidD = 1'b0;
    tick();
    check_value("fi_bubble", 64'(BubbleCnt), 64'd2);
    StallE = 1'b1;  ValidD = 1'b1;
    tick();
    check_value("fsi_bubble", 64'(BubbleCnt), 64'd2);
    check_value("fsi_stallc", 64'(StallCnt), 64'd3);

    // Invalid slot in normal mode still loads data
    StallE = 1'b0;  FlushE = 1'b0;  ValidD = 1'b0;  PCD = 32'h300;
    tick();
    check_value("inv_pce",   64'(PCE), 64'h300);
    check_value("inv_valid", 64'(ValidE), 64'd0);

    // Stall counter saturation (starts at 3)
    StallE = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 11) check_value("sat_14", 64'(StallCnt), 64'd14);
      if (i == 12) check_value("sat_15", 64'(StallCnt), 64'd15);
    end
    check_value("sat_hold", 64'(StallCnt), 64'd15);

    // Async reset mid-stall
    StallE = 1'b0;  ValidD = 1'b1;  PCD = 32'h200;
    tick();
    check_value("pre_rst_pce", 64'(PCE), 64'h200);
    StallE = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_value("arst_pce",    64'(PCE), 64'h0);
    check_value("arst_valid",  64'(ValidE), 64'd0);
    check_value("arst_stallc", 64'(StallCnt), 64'd0);
    check_value("arst_bubble", 64'(BubbleCnt), 64'd0);
    tick();
    rst = 1'b0;  StallE = 1'b0;  PCD = 32'h204;
    tick();
    check_value("post_pce",    64'(PCE), 64'h204);
    check_value("post_valid",  64'(ValidE), 64'd1);
    check_value("post_stallc", 64'(StallCnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
